// File: rtl/fproc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fproc_arbiter
//  Purpose  : Shares one function-processor (fproc) port among N_CORES cores.
//             Requests are latched per core, granted round-robin, issued to the
//             fproc one at a time, and the result is returned to the granted
//             core as a one-cycle strobe.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             core_req/core_req_id   - per-core request pulse and function ID
//             core_resp_ready/data   - per-core completion strobe, result data
//             fproc_req_*            - valid/ready request channel to fproc
//             fproc_resp_*           - one-cycle response strobe from fproc
//             err_status             - sticky: [0] dup req, [1] timeout,
//                                      [2] spurious response
//  Revision : 1.0 - initial release
// ============================================================================
module fproc_arbiter #(
   parameter int N_CORES        = 4,
   parameter int ID_WIDTH       = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_CORES-1:0]            core_req,
   input  logic [N_CORES*ID_WIDTH-1:0]   core_req_id,
   output logic [N_CORES-1:0]            core_resp_ready,
   output logic [DATA_WIDTH-1:0]         core_resp_data,
   output logic                          fproc_req_valid,
   input  logic                          fproc_req_ready,
   output logic [ID_WIDTH-1:0]           fproc_req_id,
   output logic [$clog2(N_CORES)-1:0]    fproc_req_core,
   input  logic                          fproc_resp_valid,
   input  logic [DATA_WIDTH-1:0]         fproc_resp_data,
   output logic [2:0]                    err_status
);

   localparam int CORE_W = $clog2(N_CORES);
   localparam int TCNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RESPOND   = 2'd3
   } state_t;

   state_t                state, state_next;
   logic [N_CORES-1:0]    pending;
   logic [ID_WIDTH-1:0]   stored_id [N_CORES];
   logic [CORE_W-1:0]     last_grant, last_grant_next;
   logic [TCNT_W-1:0]     tcnt, tcnt_next;

   logic                  valid_next;
   logic [ID_WIDTH-1:0]   id_next;
   logic [CORE_W-1:0]     grant_next;
   logic [N_CORES-1:0]    resp_ready_next;
   logic [DATA_WIDTH-1:0] resp_data_next;
   logic                  set_timeout;
   logic                  clear_grant;

   logic                  sel_found;
   logic [CORE_W-1:0]     sel_idx;
   logic [CORE_W-1:0]     cand_idx;
   int                    cand;
   logic [N_CORES-1:0]    grant_onehot;
   logic [N_CORES-1:0]    clear_vec;
   logic                  timeout_hit;

   assign grant_onehot = N_CORES'(1) << fproc_req_core;
   assign clear_vec    = clear_grant ? grant_onehot : '0;

   // Counter holds completed wait cycles; expiry fires in the TIMEOUT_CYCLES-th
   // wait cycle, where a simultaneous response still takes precedence.
   assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (int'(tcnt) == TIMEOUT_CYCLES - 1);

   // Round-robin search: first pending core at or after last_grant+1 (wrapping).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= N_CORES; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= N_CORES) cand = cand - N_CORES;
         cand_idx = CORE_W'(cand);
         if (!sel_found && pending[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next      = state;
      valid_next      = fproc_req_valid;
      id_next         = fproc_req_id;
      grant_next      = fproc_req_core;
      resp_ready_next = '0;
      resp_data_next  = core_resp_data;
      tcnt_next       = tcnt;
      last_grant_next = last_grant;
      set_timeout     = 1'b0;
      clear_grant     = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               grant_next = sel_idx;
               id_next    = stored_id[sel_idx];
               valid_next = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (fproc_req_ready) begin
               valid_next = 1'b0;
               tcnt_next  = '0;
               state_next = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (fproc_resp_valid) begin
               resp_data_next  = fproc_resp_data;
               resp_ready_next = grant_onehot;
               state_next      = RESPOND;
            end else if (timeout_hit) begin
               resp_data_next  = '0;
               resp_ready_next = grant_onehot;
               set_timeout     = 1'b1;
               state_next      = RESPOND;
            end else begin
               tcnt_next = tcnt + TCNT_W'(1);
            end
         end
         RESPOND: begin
            clear_grant     = 1'b1;
            last_grant_next = fproc_req_core;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         fproc_req_valid <= 1'b0;
         fproc_req_id    <= '0;
         fproc_req_core  <= '0;
         core_resp_ready <= '0;
         core_resp_data  <= '0;
         tcnt            <= '0;
         last_grant      <= CORE_W'(N_CORES - 1);
      end else begin
         state           <= state_next;
         fproc_req_valid <= valid_next;
         fproc_req_id    <= id_next;
         fproc_req_core  <= grant_next;
         core_resp_ready <= resp_ready_next;
         core_resp_data  <= resp_data_next;
         tcnt            <= tcnt_next;
         last_grant      <= last_grant_next;
      end
   end

   // Pending bookkeeping and sticky errors. A new request in the cycle its
   // pending bit is being cleared is accepted, so set wins over clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         err_status <= '0;
         for (int i = 0; i < N_CORES; i++) stored_id[i] <= '0;
      end else begin
         for (int i = 0; i < N_CORES; i++) begin
            if (core_req[i] && (!pending[i] || clear_vec[i])) begin
               pending[i]   <= 1'b1;
               stored_id[i] <= core_req_id[i*ID_WIDTH +: ID_WIDTH];
            end else if (clear_vec[i]) begin
               pending[i] <= 1'b0;
            end
         end
         if (|(core_req & pending & ~clear_vec)) err_status[0] <= 1'b1;
         if (set_timeout)                        err_status[1] <= 1'b1;
         if (fproc_resp_valid && (state != WAIT_RESP)) err_status[2] <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fproc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fproc_arbiter
//  Purpose  : Directed self-checking bench for fproc_arbiter (4 cores,
//             8-bit IDs, 32-bit data, 8-cycle timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fproc_arbiter;

   localparam int N_CORES        = 4;
   localparam int ID_WIDTH       = 8;
   localparam int DATA_WIDTH     = 32;
   localparam int TIMEOUT_CYCLES = 8;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [N_CORES-1:0]          core_req;
   logic [N_CORES*ID_WIDTH-1:0] core_req_id;
   logic [N_CORES-1:0]          core_resp_ready;
   logic [DATA_WIDTH-1:0]       core_resp_data;
   logic                        fproc_req_valid;
   logic                        fproc_req_ready;
   logic [ID_WIDTH-1:0]         fproc_req_id;
   logic [1:0]                  fproc_req_core;
   logic                        fproc_resp_valid;
   logic [DATA_WIDTH-1:0]       fproc_resp_data;
   logic [2:0]                  err_status;

   int checks = 0;
   int errors = 0;

   fproc_arbiter #(
      .N_CORES(N_CORES), .ID_WIDTH(ID_WIDTH),
      .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_req_id(core_req_id),
      .core_resp_ready(core_resp_ready), .core_resp_data(core_resp_data),
      .fproc_req_valid(fproc_req_valid), .fproc_req_ready(fproc_req_ready),
      .fproc_req_id(fproc_req_id), .fproc_req_core(fproc_req_core),
      .fproc_resp_valid(fproc_resp_valid), .fproc_resp_data(fproc_resp_data),
      .err_status(err_status)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_id(input int core, input logic [7:0] id);
      core_req_id[core*ID_WIDTH +: ID_WIDTH] = id;
   endtask

   // Waits for a grant (ready held 1), checks it, answers one cycle after
   // the accept and checks the completion strobe. Returns in the RESPOND cycle.
   task automatic serve(input string tag, input int ecore, input logic [7:0] eid,
                        input logic [31:0] data);
      int n;
      n = 0;
      while (!fproc_req_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, fproc_req_valid, 1);
      chk({tag, "_core"},  fproc_req_core, ecore);
      chk({tag, "_id"},    fproc_req_id, eid);
      tick();
      fproc_resp_valid = 1'b1;
      fproc_resp_data  = data;
      tick();
      fproc_resp_valid = 1'b0;
      chk({tag, "_rdy"},  core_resp_ready, 64'(1) << ecore);
      chk({tag, "_data"}, core_resp_data, data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b0;
      core_req         = '0;
      core_req_id      = '0;
      fproc_req_ready  = 1'b1;
      fproc_resp_valid = 1'b0;
      fproc_resp_data  = '0;

      // ---- reset state
      do_reset();
      chk("rst_valid", fproc_req_valid, 0);
      chk("rst_id",    fproc_req_id, 0);
      chk("rst_core",  fproc_req_core, 0);
      chk("rst_rdy",   core_resp_ready, 0);
      chk("rst_data",  core_resp_data, 0);
      chk("rst_err",   err_status, 0);

      // ---- single request: core 2, ID 0x15, pulse in cycle t
      core_req[2] = 1'b1;
      set_id(2, 8'h15);
      tick();                                   // t+1
      core_req = '0;
      chk("single_t1_valid", fproc_req_valid, 0);
      tick();                                   // t+2: request visible, accepted
      chk("single_t2_valid", fproc_req_valid, 1);
      chk("single_t2_id",    fproc_req_id, 8'h15);
      chk("single_t2_core",  fproc_req_core, 2);
      tick();                                   // t+3: WAIT_RESP
      chk("single_t3_valid", fproc_req_valid, 0);
      fproc_resp_valid = 1'b1;
      fproc_resp_data  = 32'hDEADBEEF;
      tick();                                   // t+4
      fproc_resp_valid = 1'b0;
      chk("single_t4_rdy",  core_resp_ready, 4'b0100);
      chk("single_t4_data", core_resp_data, 32'hDEADBEEF);
      tick();                                   // t+5
      chk("single_t5_rdy",  core_resp_ready, 0);
      chk("single_err",     err_status, 0);

      // ---- round robin from reset: cores 0,1,3 together
      do_reset();
      core_req = 4'b1011;
      set_id(0, 8'hA0); set_id(1, 8'hA1); set_id(3, 8'hA3);
      tick();
      core_req = '0;
      serve("rr1_c0", 0, 8'hA0, 32'h0000_1000);
      serve("rr1_c1", 1, 8'hA1, 32'h0000_1001);
      serve("rr1_c3", 3, 8'hA3, 32'h0000_1003);
      // Re-request during core 3's completion cycle: set must beat clear.
      core_req = 4'b1011;
      set_id(0, 8'hB0); set_id(1, 8'hB1); set_id(3, 8'hB3);
      tick();
      core_req = '0;
      serve("rr2_c0", 0, 8'hB0, 32'h0000_2000);
      serve("rr2_c1", 1, 8'hB1, 32'h0000_2001);
      serve("rr2_c3", 3, 8'hB3, 32'h0000_2003);
      chk("rr_err", err_status, 0);
      tick();
      tick();
      tick();
      chk("rr_idle_valid", fproc_req_valid, 0);

      // ---- backpressure: ready low 5 cycles, accept on the 6th
      fproc_req_ready = 1'b0;
      core_req[1] = 1'b1;
      set_id(1, 8'h42);
      tick();
      core_req = '0;
      tick();                                   // t+2
      for (int k = 0; k < 6; k++) begin
         chk("bp_valid", fproc_req_valid, 1);
         chk("bp_id",    fproc_req_id, 8'h42);
         chk("bp_core",  fproc_req_core, 1);
         if (k == 5) fproc_req_ready = 1'b1;
         tick();
      end
      chk("bp_after_valid", fproc_req_valid, 0);
      fproc_resp_valid = 1'b1;
      fproc_resp_data  = 32'h1234_5678;
      tick();
      fproc_resp_valid = 1'b0;
      chk("bp_rdy",  core_resp_ready, 4'b0010);
      chk("bp_data", core_resp_data, 32'h1234_5678);
      chk("bp_err",  err_status, 0);

      // ---- timeout: accept in cycle a, 8 silent wait cycles, strobe at a+9
      tick();
      core_req[3] = 1'b1;
      set_id(3, 8'h77);
      tick();
      core_req = '0;
      tick();                                   // a: accepted
      chk("to_valid", fproc_req_valid, 1);
      chk("to_core",  fproc_req_core, 3);
      for (int k = 0; k < 8; k++) tick();       // a+8
      chk("to_early_rdy", core_resp_ready, 0);
      tick();                                   // a+9
      chk("to_rdy",  core_resp_ready, 4'b1000);
      chk("to_data", core_resp_data, 0);
      chk("to_err",  err_status, 3'b010);
      tick();                                   // IDLE: late response
      fproc_resp_valid = 1'b1;
      fproc_resp_data  = 32'hCAFE_F00D;
      tick();
      fproc_resp_valid = 1'b0;
      chk("late_err", err_status, 3'b110);
      chk("late_rdy", core_resp_ready, 0);

      // ---- duplicate request on core 1
      do_reset();
      core_req[1] = 1'b1;
      set_id(1, 8'h03);
      tick();                                   // t+1
      set_id(1, 8'h07);
      tick();                                   // t+2
      core_req = '0;
      chk("dup_valid", fproc_req_valid, 1);
      chk("dup_id",    fproc_req_id, 8'h03);
      chk("dup_err",   err_status, 3'b001);
      tick();
      fproc_resp_valid = 1'b1;
      fproc_resp_data  = 32'h0000_0033;
      tick();                                   // t+4
      fproc_resp_valid = 1'b0;
      chk("dup_rdy", core_resp_ready, 4'b0010);
      tick();
      tick();
      tick();
      chk("dup_no_second_valid", fproc_req_valid, 0);
      chk("dup_no_second_rdy",   core_resp_ready, 0);

      // ---- reset in WAIT_RESP
      core_req[0] = 1'b1;
      set_id(0, 8'h55);
      tick();
      core_req = '0;
      tick();                                   // accepted
      tick();                                   // WAIT_RESP
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", fproc_req_valid, 0);
      chk("mid_rst_id",    fproc_req_id, 0);
      chk("mid_rst_core",  fproc_req_core, 0);
      chk("mid_rst_rdy",   core_resp_ready, 0);
      chk("mid_rst_data",  core_resp_data, 0);
      chk("mid_rst_err",   err_status, 0);
      fproc_resp_valid = 1'b1;
      fproc_resp_data  = 32'h5555_AAAA;
      tick();
      fproc_resp_valid = 1'b0;
      chk("mid_rst_spur_err", err_status, 3'b100);
      chk("mid_rst_spur_rdy", core_resp_ready, 0);
      tick();
      tick();
      chk("mid_rst_no_valid", fproc_req_valid, 0);
      chk("mid_rst_no_rdy",   core_resp_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
